// File: rtl/ls1u_ahb_pkg.sv
// Shared definitions for the 8-bit system AHB and the SRAM responder state machine.
package ls1u_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // RWAIT holds the extra read wait cycles that follow the single RD access cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_DATA,
    ST_RD,
    ST_RWAIT,
    ST_RDONE,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // True when addr lies in the naturally aligned 2^aw byte window starting at base.
  function automatic logic inWindow(logic [23:0] addr, logic [23:0] base, int aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter that times the wait states of a data phase.
module ahb_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] countQ, countD;

  // Load takes priority over decrement; the counter parks at zero.
  always_comb begin
    countD = countQ;
    if (load_i) begin
      countD = loadValue_i;
    end else if (dec_i && (countQ != '0)) begin
      countD = countQ - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign done_o = (countQ == '0);

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB responder mapping one address window onto a 1-cycle-latency single-port SRAM.
module ahb_sram_responder
  import ls1u_ahb_pkg::*;
#(
  parameter logic [23:0] BASE        = 24'h000000,
  parameter int          ADDR_W      = 16,
  parameter int          WAIT_STATES = 0,
  parameter bit          READ_ONLY   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [23:0]       haddr,
  input  logic              hwrite,
  input  logic [2:0]        hburst,
  input  logic [1:0]        htrans,
  input  logic [7:0]        hwdata,
  output logic              hready,
  output logic              hresp,
  output logic [7:0]        hrdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  sram_state_e       stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              rdCaptureQ;
  logic [7:0]        rdBufQ;
  logic [7:0]        hrdataQ;
  logic              cntLoad, cntDec, cntDone;
  logic              transStart, transErr;

  assign transStart = hsel && htrans[1];
  assign transErr   = !inWindow(haddr, BASE, ADDR_W) || (READ_ONLY && hwrite);

  ahb_wait_counter #(.WIDTH(4)) waitCounter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cntLoad),
    .loadValue_i (WAIT_LOAD),
    .dec_i       (cntDec),
    .done_o      (cntDone)
  );

  // Next-state logic; every hready=1 state doubles as an address phase for the next transfer.
  always_comb begin
    stateD  = stateQ;
    addrD   = addrQ;
    cntLoad = 1'b0;
    cntDec  = 1'b0;
    case (stateQ)
      ST_WWAIT: begin
        if (cntDone) stateD = ST_DATA;
        else         cntDec = 1'b1;
      end
      ST_RD: begin
        if (HAS_WAIT) begin
          stateD  = ST_RWAIT;
          cntLoad = 1'b1;
        end else begin
          stateD = ST_RDONE;
        end
      end
      ST_RWAIT: begin
        if (cntDone) stateD = ST_RDONE;
        else         cntDec = 1'b1;
      end
      ST_ERR1: stateD = ST_ERR2;
      default: begin
        stateD = ST_IDLE;
        if (transStart) begin
          if (transErr) begin
            stateD = ST_ERR1;
          end else begin
            addrD = haddr[ADDR_W-1:0];
            if (!hwrite) begin
              stateD = ST_RD;
            end else if (HAS_WAIT) begin
              stateD  = ST_WWAIT;
              cntLoad = 1'b1;
            end else begin
              stateD = ST_DATA;
            end
          end
        end
      end
    endcase
  end

  // State and read-data registers; a reset mid-transfer simply abandons it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= ST_IDLE;
      addrQ      <= '0;
      rdCaptureQ <= 1'b0;
      rdBufQ     <= '0;
      hrdataQ    <= '0;
    end else begin
      stateQ     <= stateD;
      addrQ      <= addrD;
      rdCaptureQ <= (stateQ == ST_RD);
      if (rdCaptureQ) rdBufQ <= ram_rdata;
      if (stateQ == ST_RDONE) hrdataQ <= hrdata;
    end
  end

  assign hready    = !((stateQ == ST_WWAIT) || (stateQ == ST_RD) ||
                       (stateQ == ST_RWAIT) || (stateQ == ST_ERR1));
  assign hresp     = ((stateQ == ST_ERR1) || (stateQ == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign ram_en    = (stateQ == ST_DATA) || (stateQ == ST_RD);
  assign ram_we    = (stateQ == ST_DATA);
  assign ram_addr  = ram_en ? addrQ : '0;
  assign ram_wdata = ram_we ? hwdata : '0;

  // With no extra waits the SRAM output lands exactly in RDONE, otherwise it was buffered earlier.
  assign hrdata = (stateQ == ST_RDONE) ? (rdCaptureQ ? ram_rdata : rdBufQ) : hrdataQ;

  // A SEQ beat only makes sense inside a multi-beat burst.
  seqNeedsBurst: assert property (@(posedge clk) disable iff (rst)
    (hsel && hready && (htrans == HTRANS_SEQ)) |-> (hburst != HBURST_SINGLE));

endmodule
